// File: rtl/panda_pkg.sv
// Shared types for the panda fetch path: fetch FSM encoding and the NOP word
// used both for flushed IF slots and for idle fetch output.
package panda_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        FS_IDLE = 3'd0,
        FS_REQ  = 3'd1,
        FS_WAIT = 3'd2,
        FS_HOLD = 3'd3,
        FS_DROP = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/panda_fetch_timer.sv
// Saturating wait-cycle counter for the fetch sequencer. hit_o flags the
// cycle in which the number of counted cycles (including the current one)
// reaches TimeoutCycles.
module panda_fetch_timer #(
    parameter int TimeoutCycles = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);
    localparam int CW = (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles + 1);

    logic [CW-1:0] cnt_q;

    // count enabled cycles, hold at all-ones rather than wrap
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != {CW{1'b1}})) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign hit_o = en_i && (int'(cnt_q) >= TimeoutCycles - 1);

endmodule

// File: rtl/panda_fetch_ctrl.sv
// Fetch sequencer between panda_if_stage and a req/gnt/rvalid instruction
// memory. One outstanding fetch; stale responses after a flush are dropped and
// a word returned during a downstream stall is parked in a one-entry buffer.
// Optional: define PANDA_FETCH_TIMEOUT_EN to add a sticky WAIT/DROP timeout.
module panda_fetch_ctrl
    import panda_pkg::*;
#(
    parameter int TimeoutCycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    input  logic        pipe_stall_i,
    output logic        fetch_stall_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        fetch_err_o
);
    fetch_state_e state_q, state_d;
    logic [31:0]  buf_q, buf_d;
    logic         eflush, in_wait, in_hold, deliver;

    // a flush under downstream stall is ignored, matching the IF stage;
    // outputs are forced to their idle values while reset is asserted
    always_comb begin
        eflush  = flush_i & ~pipe_stall_i;
        in_wait = ~rst_i & (state_q == FS_WAIT);
        in_hold = ~rst_i & (state_q == FS_HOLD);
        deliver = ~pipe_stall_i & ~flush_i & ((in_wait & instr_rvalid_i) | in_hold);

        fetch_stall_o = pipe_stall_i | (~deliver & ~eflush);
        instr_req_o   = ~rst_i & (state_q == FS_REQ);
        instr_addr_o  = pc_i;
        if (in_wait && deliver) begin
            instr_rdata_o = instr_rdata_i;
        end else if (in_hold) begin
            instr_rdata_o = buf_q;
        end else begin
            instr_rdata_o = NOP_INSTR;
        end
    end

    // next-state and buffer capture
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        unique case (state_q)
            FS_IDLE: state_d = FS_REQ;
            FS_REQ: begin
                if (eflush) begin
                    state_d = instr_gnt_i ? FS_DROP : FS_IDLE;
                end else if (instr_gnt_i) begin
                    state_d = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (instr_rvalid_i) begin
                    if (eflush) begin
                        state_d = FS_IDLE;
                    end else if (!pipe_stall_i) begin
                        state_d = FS_REQ;
                    end else begin
                        buf_d   = instr_rdata_i;
                        state_d = FS_HOLD;
                    end
                end else if (eflush) begin
                    state_d = FS_DROP;
                end
            end
            FS_HOLD: begin
                if (eflush) begin
                    state_d = FS_IDLE;
                end else if (!pipe_stall_i) begin
                    state_d = FS_REQ;
                end
            end
            FS_DROP: begin
                if (instr_rvalid_i) begin
                    state_d = FS_REQ;
                end
            end
            default: state_d = FS_IDLE;
        endcase
    end

    // state and buffer registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FS_IDLE;
            buf_q   <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
        end
    end

`ifdef PANDA_FETCH_TIMEOUT_EN
    logic timer_act, timer_hit, err_q;

    assign timer_act = ~rst_i & ((state_q == FS_WAIT) | (state_q == FS_DROP));

    panda_fetch_timer #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (~timer_act),
        .en_i  (timer_act),
        .hit_o (timer_hit)
    );

    // sticky error; only reset clears it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | timer_hit;
        end
    end

    assign fetch_err_o = ~rst_i & (err_q | timer_hit);
`else
    // no timer in this build: constant 0 (the compare is never true)
    assign fetch_err_o = (TimeoutCycles < 0);
`endif

endmodule

// File: tb/tb_panda_fetch_ctrl.sv
module tb_panda_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        flush, pstall, gnt, rvalid;
    logic [31:0] rdata_i;
    logic        fetch_stall, req, err;
    logic [31:0] rdata_o, addr;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    panda_fetch_ctrl #(.TimeoutCycles(4)) dut (
        .clk_i(clk), .rst_i(rst), .pc_i(pc), .flush_i(flush),
        .pipe_stall_i(pstall), .fetch_stall_o(fetch_stall),
        .instr_rdata_o(rdata_o), .instr_req_o(req), .instr_addr_o(addr),
        .instr_gnt_i(gnt), .instr_rvalid_i(rvalid), .instr_rdata_i(rdata_i),
        .fetch_err_o(err)
    );

    // delivery monitor: every word reaching the IF stage must be the next expected one
    always @(negedge clk) begin
        if (!rst && !fetch_stall && !(flush && !pstall)) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL deliver_unexpected got %h, no word expected", rdata_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (rdata_o !== e) begin
                    n_err++;
                    $display("FAIL deliver_data got %h want %h", rdata_o, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 0; pstall = 0; gnt = 0; rvalid = 0; rdata_i = 32'hdead_beef;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc = 32'h40; flush = 0; pstall = 0; gnt = 0; rvalid = 0; rdata_i = 0;
        tick();
        @(negedge clk);
        n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", req); end
        n_vec++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL rst_stall got %b want 1", fetch_stall); end
        n_vec++; if (rdata_o !== NOP) begin n_err++; $display("FAIL rst_rdata got %h want %h", rdata_o, NOP); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", err); end
        tick();
        flush = 1'b1;
        @(negedge clk);
        n_vec++; if (fetch_stall !== 1'b0) begin n_err++; $display("FAIL rst_flush_stall got %b want 0", fetch_stall); end
        do_reset();
    endtask

    task automatic test_zero_wait();
        do_reset(); pc = 32'h0;
        @(negedge clk);
        n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL zw_c0_req got %b want 0", req); end
        tick(); gnt = 1;
        @(negedge clk);
        n_vec++; if (req !== 1'b1 || addr !== 32'h0) begin n_err++; $display("FAIL zw_c1_req got %b/%h want 1/0", req, addr); end
        n_vec++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL zw_c1_stall got %b want 1", fetch_stall); end
        tick(); gnt = 0; rvalid = 1; rdata_i = 32'h0050_0093; exp_q.push_back(32'h0050_0093);
        @(negedge clk);
        n_vec++; if (fetch_stall !== 1'b0) begin n_err++; $display("FAIL zw_c2_stall got %b want 0", fetch_stall); end
        n_vec++; if (rdata_o !== 32'h0050_0093) begin n_err++; $display("FAIL zw_c2_rdata got %h want 00500093", rdata_o); end
        n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL zw_c2_req got %b want 0", req); end
        tick(); rvalid = 0; pc = 32'h4;
        @(negedge clk);
        n_vec++; if (req !== 1'b1 || addr !== 32'h4) begin n_err++; $display("FAIL zw_c3_req got %b/%h want 1/4", req, addr); end
    endtask

    task automatic test_gnt_wait();
        do_reset(); pc = 32'h100;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (req !== 1'b1 || addr !== 32'h100 || fetch_stall !== 1'b1) begin
                n_err++; $display("FAIL gw_hold%0d req/addr/stall got %b/%h/%b want 1/100/1", i, req, addr, fetch_stall);
            end
            if (i == 1) rvalid = 1; // stray rvalid in REQ must be ignored
            tick();
            rvalid = 0;
        end
        gnt = 1;
        tick(); gnt = 0; rvalid = 1; rdata_i = 32'h1234_5678; exp_q.push_back(32'h1234_5678);
        @(negedge clk);
        n_vec++; if (fetch_stall !== 1'b0 || rdata_o !== 32'h1234_5678) begin n_err++; $display("FAIL gw_deliver got %b/%h want 0/12345678", fetch_stall, rdata_o); end
        tick(); rvalid = 0;
    endtask

    task automatic test_hold();
        do_reset(); pc = 32'h80;
        tick(); gnt = 1;
        tick(); gnt = 0; rvalid = 1; rdata_i = 32'hcafe_0001; pstall = 1; exp_q.push_back(32'hcafe_0001);
        @(negedge clk);
        n_vec++; if (fetch_stall !== 1'b1 || rdata_o !== NOP) begin n_err++; $display("FAIL hold_wait got %b/%h want 1/%h", fetch_stall, rdata_o, NOP); end
        tick(); rvalid = 0; rdata_i = 32'hdead_beef;
        @(negedge clk);
        n_vec++; if (fetch_stall !== 1'b1 || rdata_o !== 32'hcafe_0001 || req !== 1'b0) begin
            n_err++; $display("FAIL hold_c1 got %b/%h/%b want 1/cafe0001/0", fetch_stall, rdata_o, req); end
        tick(); pstall = 0;
        @(negedge clk);
        n_vec++; if (fetch_stall !== 1'b0 || rdata_o !== 32'hcafe_0001) begin n_err++; $display("FAIL hold_deliver got %b/%h want 0/cafe0001", fetch_stall, rdata_o); end
        tick();
        @(negedge clk);
        n_vec++; if (req !== 1'b1) begin n_err++; $display("FAIL hold_next_req got %b want 1", req); end
    endtask

    task automatic test_flush_stalled();
        do_reset(); pc = 32'h90;
        tick(); gnt = 1;
        tick(); gnt = 0; rvalid = 1; rdata_i = 32'hbeef_0002; pstall = 1; flush = 1; exp_q.push_back(32'hbeef_0002);
        @(negedge clk);
        n_vec++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL fs_wait_stall got %b want 1", fetch_stall); end
        tick(); rvalid = 0;
        @(negedge clk);
        n_vec++; if (rdata_o !== 32'hbeef_0002 || fetch_stall !== 1'b1) begin n_err++; $display("FAIL fs_hold got %h/%b want beef0002/1", rdata_o, fetch_stall); end
        tick(); flush = 0; pstall = 0;
        @(negedge clk);
        n_vec++; if (fetch_stall !== 1'b0 || rdata_o !== 32'hbeef_0002) begin n_err++; $display("FAIL fs_deliver got %b/%h want 0/beef0002", fetch_stall, rdata_o); end
        tick();
    endtask

    task automatic test_flush_wait();
        do_reset(); pc = 32'h200;
        tick(); gnt = 1;
        tick(); gnt = 0; flush = 1;
        @(negedge clk);
        n_vec++; if (fetch_stall !== 1'b0 || req !== 1'b0) begin n_err++; $display("FAIL fw_flush got stall %b req %b want 0/0", fetch_stall, req); end
        tick(); flush = 0; pc = 32'h300;
        @(negedge clk);
        n_vec++; if (fetch_stall !== 1'b1 || req !== 1'b0) begin n_err++; $display("FAIL fw_drop1 got stall %b req %b want 1/0", fetch_stall, req); end
        tick(); rvalid = 1; rdata_i = 32'h5a5a_5a5a;
        @(negedge clk);
        n_vec++; if (fetch_stall !== 1'b1 || rdata_o !== NOP) begin n_err++; $display("FAIL fw_stale got %b/%h want 1/%h", fetch_stall, rdata_o, NOP); end
        tick(); rvalid = 0;
        @(negedge clk);
        n_vec++; if (req !== 1'b1 || addr !== 32'h300) begin n_err++; $display("FAIL fw_redirect got %b/%h want 1/300", req, addr); end
        gnt = 1;
        tick(); gnt = 0; rvalid = 1; rdata_i = 32'h0000_0300; exp_q.push_back(32'h0000_0300);
        @(negedge clk);
        n_vec++; if (fetch_stall !== 1'b0) begin n_err++; $display("FAIL fw_new_deliver got %b want 0", fetch_stall); end
        tick(); rvalid = 0;
    endtask

    task automatic test_flush_req();
        do_reset(); pc = 32'h10;
        tick(); flush = 1;
        @(negedge clk);
        n_vec++; if (fetch_stall !== 1'b0) begin n_err++; $display("FAIL fr_flush_stall got %b want 0", fetch_stall); end
        tick(); flush = 0; pc = 32'h20;
        @(negedge clk);
        n_vec++; if (req !== 1'b0 || fetch_stall !== 1'b1) begin n_err++; $display("FAIL fr_idle got req %b stall %b want 0/1", req, fetch_stall); end
        tick();
        @(negedge clk);
        n_vec++; if (req !== 1'b1 || addr !== 32'h20) begin n_err++; $display("FAIL fr_req got %b/%h want 1/20", req, addr); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        do_reset();
        tick();
        for (int k = 0; k < 4; k++) begin
            pc = 32'h1000 + 32'(4 * k); gnt = 1;
            @(negedge clk);
            n_vec++; if (req !== 1'b1 || addr !== pc) begin n_err++; $display("FAIL b2b_req%0d got %b/%h want 1/%h", k, req, addr, pc); end
            tick();
            w = $urandom(); gnt = 0; rvalid = 1; rdata_i = w; exp_q.push_back(w);
            tick();
            rvalid = 0;
        end
    endtask

    task automatic test_reset_mid();
        do_reset(); pc = 32'h50;
        tick(); gnt = 1;
        tick(); gnt = 0; rst = 1;
        tick(); rst = 0; rvalid = 1; rdata_i = 32'h7777_7777;
        @(negedge clk);
        n_vec++; if (fetch_stall !== 1'b1 || req !== 1'b0) begin n_err++; $display("FAIL rm_idle got stall %b req %b want 1/0", fetch_stall, req); end
        tick(); rvalid = 0;
        @(negedge clk);
        n_vec++; if (req !== 1'b1 || fetch_stall !== 1'b1) begin n_err++; $display("FAIL rm_req got req %b stall %b want 1/1", req, fetch_stall); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rm_err got %b want 0", err); end
    endtask

`ifdef PANDA_FETCH_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        tick(); gnt = 1;
        tick(); gnt = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_vec++; if (err !== (k >= 4)) begin n_err++; $display("FAIL to_wait%0d got %b want %b", k, err, (k >= 4)); end
            tick();
        end
        flush = 1;
        tick(); flush = 0;
        @(negedge clk);
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL to_sticky got %b want 1", err); end
        do_reset();
        @(negedge clk);
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL to_cleared got %b want 0", err); end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait();
        test_gnt_wait();
        test_hold();
        test_flush_stalled();
        test_flush_wait();
        test_flush_req();
        test_back_to_back();
        test_reset_mid();
`ifdef PANDA_FETCH_TIMEOUT_EN
        test_timeout();
`endif
        tick();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
